// File: rtl/alu_pkg.sv
// Shared ALU definitions: 4-bit ALU control codes, RV32I opcodes and branch funct3 values.
package alu_pkg;

  localparam logic [3:0] AluAnd  = 4'b0000;
  localparam logic [3:0] AluOr   = 4'b0001;
  localparam logic [3:0] AluAdd  = 4'b0010;
  localparam logic [3:0] AluSra  = 4'b0011;
  localparam logic [3:0] AluSub  = 4'b0110;
  localparam logic [3:0] AluSlt  = 4'b0111;
  localparam logic [3:0] AluSll  = 4'b1000;
  localparam logic [3:0] AluSrl  = 4'b1001;
  localparam logic [3:0] AluXor  = 4'b1010;
  localparam logic [3:0] AluNor  = 4'b1100;
  localparam logic [3:0] AluBeq  = 4'b1110;
  localparam logic [3:0] AluSltu = 4'b1111;

  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcJal    = 7'b1101111;

  localparam logic [2:0] F3Beq  = 3'b000;
  localparam logic [2:0] F3Bne  = 3'b001;
  localparam logic [2:0] F3Blt  = 3'b100;
  localparam logic [2:0] F3Bge  = 3'b101;
  localparam logic [2:0] F3Bltu = 3'b110;
  localparam logic [2:0] F3Bgeu = 3'b111;

  function automatic logic uses_rs1(input logic [6:0] opc);
    return opc inside {OpcOp, OpcOpImm, OpcLoad, OpcStore, OpcBranch, OpcJalr};
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    return opc inside {OpcOp, OpcStore, OpcBranch};
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Decode-side beat, forwarding sources and EX-slot outputs of the ALU issue stage.
interface alu_issue_stage_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        in_opcode;
  logic [2:0]        in_funct3;
  logic              in_funct7_b5;
  logic [XLEN-1:0]   in_pc;
  logic [XLEN-1:0]   in_imm;
  logic [REG_AW-1:0] in_rs1_addr;
  logic [REG_AW-1:0] in_rs2_addr;
  logic [REG_AW-1:0] in_rd_addr;
  logic [XLEN-1:0]   in_rs1_data;
  logic [XLEN-1:0]   in_rs2_data;
  logic [XLEN-1:0]   fwd_ex_data;
  logic              fwd_mem_valid;
  logic              fwd_wb_valid;
  logic [REG_AW-1:0] fwd_mem_rd;
  logic [REG_AW-1:0] fwd_wb_rd;
  logic [XLEN-1:0]   fwd_mem_data;
  logic [XLEN-1:0]   fwd_wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_src_a;
  logic [XLEN-1:0]   out_src_b;
  logic [3:0]        out_alu_control;
  logic [REG_AW-1:0] out_rd_addr;
  logic              out_rd_we;
  logic              out_is_load;
  logic              out_is_store;
  logic              out_is_branch;
  logic              out_is_jump;
  logic              out_illegal;
  logic              out_br_on_zero;
  logic [XLEN-1:0]   out_store_data;
  logic [XLEN-1:0]   out_pc;

  modport master (
    output flush, in_valid, in_opcode, in_funct3, in_funct7_b5, in_pc, in_imm,
           in_rs1_addr, in_rs2_addr, in_rd_addr, in_rs1_data, in_rs2_data,
           fwd_ex_data, fwd_mem_valid, fwd_wb_valid, fwd_mem_rd, fwd_wb_rd,
           fwd_mem_data, fwd_wb_data, out_ready,
    input  in_ready, out_valid, out_src_a, out_src_b, out_alu_control, out_rd_addr,
           out_rd_we, out_is_load, out_is_store, out_is_branch, out_is_jump,
           out_illegal, out_br_on_zero, out_store_data, out_pc
  );

  modport slave (
    input  flush, in_valid, in_opcode, in_funct3, in_funct7_b5, in_pc, in_imm,
           in_rs1_addr, in_rs2_addr, in_rd_addr, in_rs1_data, in_rs2_data,
           fwd_ex_data, fwd_mem_valid, fwd_wb_valid, fwd_mem_rd, fwd_wb_rd,
           fwd_mem_data, fwd_wb_data, out_ready,
    output in_ready, out_valid, out_src_a, out_src_b, out_alu_control, out_rd_addr,
           out_rd_we, out_is_load, out_is_store, out_is_branch, out_is_jump,
           out_illegal, out_br_on_zero, out_store_data, out_pc
  );
endinterface

// File: rtl/alu_fwd_mux.sv
// Operand forwarding select: x0, then EX slot, MEM, WB, and finally register-file data.
module alu_fwd_mux #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_addr_i,
  input  logic [XLEN-1:0]   rf_data_i,
  input  logic              ex_hit_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic [XLEN-1:0]   ex_data_i,
  input  logic              mem_valid_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic [XLEN-1:0]   mem_data_i,
  input  logic              wb_valid_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic [XLEN-1:0]   wb_data_i,
  output logic [XLEN-1:0]   data_o
);

  always_comb begin
    data_o = rf_data_i;
    if (rs_addr_i == '0) begin
      data_o = '0;
    end else if (ex_hit_i && (ex_rd_i == rs_addr_i)) begin
      data_o = ex_data_i;
    end else if (mem_valid_i && (mem_rd_i == rs_addr_i)) begin
      data_o = mem_data_i;
    end else if (wb_valid_i && (wb_rd_i == rs_addr_i)) begin
      data_o = wb_data_i;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes RV32I into ALU control, forwards operands, and holds one EX slot.
module alu_issue_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input logic               clk,
  input logic               rst_n,
  alu_issue_stage_if.slave  bus
);
  import alu_pkg::*;

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   src_a_q, src_b_q, store_data_q, pc_q;
  logic [3:0]        ctrl_q;
  logic [REG_AW-1:0] rd_q;
  logic              rd_we_q, is_load_q, is_store_q, is_branch_q, is_jump_q, illegal_q, boz_q;

  logic [XLEN-1:0] rs1_val, rs2_val, dec_a, dec_b;
  logic [3:0]      dec_ctrl;
  logic            dec_we, dec_load, dec_store, dec_branch, dec_jump, dec_illegal, dec_boz;
  logic            advance, stall, load_beat, ex_hit, rs1_hit, rs2_hit;

  // Loads are excluded here: their data only exists from MEM onwards.
  assign ex_hit = valid_q & rd_we_q & ~is_load_q;

  alu_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_a (
    .rs_addr_i   (bus.in_rs1_addr),
    .rf_data_i   (bus.in_rs1_data),
    .ex_hit_i    (ex_hit),
    .ex_rd_i     (rd_q),
    .ex_data_i   (bus.fwd_ex_data),
    .mem_valid_i (bus.fwd_mem_valid),
    .mem_rd_i    (bus.fwd_mem_rd),
    .mem_data_i  (bus.fwd_mem_data),
    .wb_valid_i  (bus.fwd_wb_valid),
    .wb_rd_i     (bus.fwd_wb_rd),
    .wb_data_i   (bus.fwd_wb_data),
    .data_o      (rs1_val)
  );

  alu_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_b (
    .rs_addr_i   (bus.in_rs2_addr),
    .rf_data_i   (bus.in_rs2_data),
    .ex_hit_i    (ex_hit),
    .ex_rd_i     (rd_q),
    .ex_data_i   (bus.fwd_ex_data),
    .mem_valid_i (bus.fwd_mem_valid),
    .mem_rd_i    (bus.fwd_mem_rd),
    .mem_data_i  (bus.fwd_mem_data),
    .wb_valid_i  (bus.fwd_wb_valid),
    .wb_rd_i     (bus.fwd_wb_rd),
    .wb_data_i   (bus.fwd_wb_data),
    .data_o      (rs2_val)
  );

  always_comb begin
    dec_ctrl    = AluAdd;
    dec_a       = rs1_val;
    dec_b       = bus.in_imm;
    dec_we      = 1'b0;
    dec_load    = 1'b0;
    dec_store   = 1'b0;
    dec_branch  = 1'b0;
    dec_jump    = 1'b0;
    dec_illegal = 1'b0;
    dec_boz     = 1'b0;
    case (bus.in_opcode)
      OpcOp, OpcOpImm: begin
        dec_we = 1'b1;
        if (bus.in_opcode == OpcOp) dec_b = rs2_val;
        case (bus.in_funct3)
          3'b000:  dec_ctrl = (bus.in_opcode == OpcOp && bus.in_funct7_b5) ? AluSub : AluAdd;
          3'b001:  dec_ctrl = AluSll;
          3'b010:  dec_ctrl = AluSlt;
          3'b011:  dec_ctrl = AluSltu;
          3'b100:  dec_ctrl = AluXor;
          3'b101:  dec_ctrl = bus.in_funct7_b5 ? AluSra : AluSrl;
          3'b110:  dec_ctrl = AluOr;
          default: dec_ctrl = AluAnd;
        endcase
      end
      OpcLoad: begin
        dec_we   = 1'b1;
        dec_load = 1'b1;
      end
      OpcStore: dec_store = 1'b1;
      OpcLui: begin
        dec_a  = '0;
        dec_we = 1'b1;
      end
      OpcAuipc: begin
        dec_a  = bus.in_pc;
        dec_we = 1'b1;
      end
      OpcJal, OpcJalr: begin
        dec_a    = bus.in_pc;
        dec_b    = XLEN'(4);
        dec_we   = 1'b1;
        dec_jump = 1'b1;
      end
      OpcBranch: begin
        dec_b      = rs2_val;
        dec_branch = 1'b1;
        case (bus.in_funct3)
          F3Beq:   dec_ctrl = AluBeq;
          F3Bne:   begin dec_ctrl = AluBeq;  dec_boz = 1'b1; end
          F3Blt:   dec_ctrl = AluSlt;
          F3Bge:   begin dec_ctrl = AluSlt;  dec_boz = 1'b1; end
          F3Bltu:  dec_ctrl = AluSltu;
          F3Bgeu:  begin dec_ctrl = AluSltu; dec_boz = 1'b1; end
          default: begin dec_branch = 1'b0;  dec_illegal = 1'b1; end
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
    if (bus.in_rd_addr == '0) dec_we = 1'b0;
  end

  assign rs1_hit   = uses_rs1(bus.in_opcode) && (bus.in_rs1_addr == rd_q);
  assign rs2_hit   = uses_rs2(bus.in_opcode) && (bus.in_rs2_addr == rd_q);
  assign advance   = bus.out_ready | ~valid_q;
  assign stall     = bus.in_valid & valid_q & is_load_q & rd_we_q & (rs1_hit | rs2_hit) & advance;
  assign load_beat = ~bus.flush & advance & bus.in_valid & ~stall;
  assign bus.in_ready = bus.flush | (advance & ~stall);

  always_comb begin
    valid_d = valid_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (advance) begin
      valid_d = load_beat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      src_a_q      <= '0;
      src_b_q      <= '0;
      store_data_q <= '0;
      pc_q         <= '0;
      ctrl_q       <= AluAnd;
      rd_q         <= '0;
      rd_we_q      <= 1'b0;
      is_load_q    <= 1'b0;
      is_store_q   <= 1'b0;
      is_branch_q  <= 1'b0;
      is_jump_q    <= 1'b0;
      illegal_q    <= 1'b0;
      boz_q        <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (load_beat) begin
        src_a_q      <= dec_a;
        src_b_q      <= dec_b;
        store_data_q <= rs2_val;
        pc_q         <= bus.in_pc;
        ctrl_q       <= dec_ctrl;
        rd_q         <= bus.in_rd_addr;
        rd_we_q      <= dec_we;
        is_load_q    <= dec_load;
        is_store_q   <= dec_store;
        is_branch_q  <= dec_branch;
        is_jump_q    <= dec_jump;
        illegal_q    <= dec_illegal;
        boz_q        <= dec_boz;
      end
    end
  end

  assign bus.out_valid       = valid_q;
  assign bus.out_src_a       = src_a_q;
  assign bus.out_src_b       = src_b_q;
  assign bus.out_alu_control = ctrl_q;
  assign bus.out_rd_addr     = rd_q;
  assign bus.out_rd_we       = rd_we_q;
  assign bus.out_is_load     = is_load_q;
  assign bus.out_is_store    = is_store_q;
  assign bus.out_is_branch   = is_branch_q;
  assign bus.out_is_jump     = is_jump_q;
  assign bus.out_illegal     = illegal_q;
  assign bus.out_br_on_zero  = boz_q;
  assign bus.out_store_data  = store_data_q;
  assign bus.out_pc          = pc_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed and randomized checks of alu_issue_stage against an in-bench behavioural model.
module tb_alu_issue_stage;

  localparam logic [6:0] OPC_OP = 7'h33, OPC_OPI = 7'h13, OPC_LD = 7'h03, OPC_ST = 7'h23;
  localparam logic [6:0] OPC_BR = 7'h63, OPC_LUI = 7'h37, OPC_AUIPC = 7'h17;
  localparam logic [6:0] OPC_JAL = 7'h6f, OPC_JALR = 7'h67;

  typedef struct packed {
    logic        valid;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        we, is_load, is_store, is_branch, is_jump, illegal, boz;
    logic [31:0] store_data;
    logic [31:0] pc;
  } slot_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  slot_t exp_s, act_s;
  logic exp_in_ready, act_in_ready;
  logic [6:0] opc_tab [10] = '{OPC_OP, OPC_OPI, OPC_LD, OPC_ST, OPC_BR, OPC_LUI, OPC_AUIPC,
                               OPC_JAL, OPC_JALR, 7'h7f};

  alu_issue_stage_if #(.XLEN(32), .REG_AW(5)) bus ();

  alu_issue_stage #(.XLEN(32), .REG_AW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  always_comb begin
    act_s = '{valid: bus.out_valid, src_a: bus.out_src_a, src_b: bus.out_src_b,
              ctrl: bus.out_alu_control, rd: bus.out_rd_addr, we: bus.out_rd_we,
              is_load: bus.out_is_load, is_store: bus.out_is_store,
              is_branch: bus.out_is_branch, is_jump: bus.out_is_jump,
              illegal: bus.out_illegal, boz: bus.out_br_on_zero,
              store_data: bus.out_store_data, pc: bus.out_pc};
  end

  // Reference decode from the instruction-class rules, table-driven.
  function automatic slot_t model_decode(input logic [6:0] opc, input logic [2:0] f3,
                                         input logic f7, input logic [4:0] rd,
                                         input logic [31:0] a1, a2, imm, pc);
    logic [3:0] op_tab [8];
    slot_t s;
    op_tab = '{4'b0010, 4'b1000, 4'b0111, 4'b1111, 4'b1010, 4'b1001, 4'b0001, 4'b0000};
    s = '0;
    s.valid = 1'b1; s.rd = rd; s.pc = pc; s.ctrl = 4'b0010; s.store_data = a2;
    case (opc)
      OPC_OP: begin
        s.src_a = a1; s.src_b = a2; s.we = 1'b1; s.ctrl = op_tab[f3];
        if (f7 && f3 == 3'd0) s.ctrl = 4'b0110;
        if (f7 && f3 == 3'd5) s.ctrl = 4'b0011;
      end
      OPC_OPI: begin
        s.src_a = a1; s.src_b = imm; s.we = 1'b1; s.ctrl = op_tab[f3];
        if (f7 && f3 == 3'd5) s.ctrl = 4'b0011;
      end
      OPC_LD:    begin s.src_a = a1; s.src_b = imm; s.we = 1'b1; s.is_load = 1'b1; end
      OPC_ST:    begin s.src_a = a1; s.src_b = imm; s.is_store = 1'b1; end
      OPC_LUI:   begin s.src_a = 32'd0; s.src_b = imm; s.we = 1'b1; end
      OPC_AUIPC: begin s.src_a = pc; s.src_b = imm; s.we = 1'b1; end
      OPC_JAL, OPC_JALR: begin s.src_a = pc; s.src_b = 32'd4; s.we = 1'b1; s.is_jump = 1'b1; end
      OPC_BR: begin
        if (f3 == 3'd2 || f3 == 3'd3) begin
          s.illegal = 1'b1;
        end else begin
          s.src_a = a1; s.src_b = a2; s.is_branch = 1'b1; s.boz = f3[0];
          s.ctrl = !f3[2] ? 4'b1110 : (f3[1] ? 4'b1111 : 4'b0111);
        end
      end
      default: s.illegal = 1'b1;
    endcase
    if (rd == 5'd0) s.we = 1'b0;
    return s;
  endfunction

  function automatic logic [31:0] model_operand(input logic [4:0] a, input logic [31:0] rf);
    if (a == 5'd0) return 32'd0;
    if (exp_s.valid && exp_s.we && !exp_s.is_load && exp_s.rd == a) return bus.fwd_ex_data;
    if (bus.fwd_mem_valid && bus.fwd_mem_rd == a) return bus.fwd_mem_data;
    if (bus.fwd_wb_valid && bus.fwd_wb_rd == a) return bus.fwd_wb_data;
    return rf;
  endfunction

  // Fields the specification leaves open are blanked before comparing.
  function automatic slot_t norm(input slot_t s);
    slot_t r;
    r = s;
    if (!r.valid) return '0;
    if (r.illegal) begin r.src_a = '0; r.src_b = '0; end
    if (!r.is_store) r.store_data = '0;
    return r;
  endfunction

  task automatic tick();
    slot_t nxt;
    logic adv, stl, u1, u2;
    @(negedge clk);
    act_in_ready = bus.in_ready;
    u1  = bus.in_opcode inside {OPC_OP, OPC_OPI, OPC_LD, OPC_ST, OPC_BR, OPC_JALR};
    u2  = bus.in_opcode inside {OPC_OP, OPC_ST, OPC_BR};
    adv = bus.out_ready || !exp_s.valid;
    stl = bus.in_valid && exp_s.valid && exp_s.is_load && exp_s.we && adv &&
          ((u1 && bus.in_rs1_addr == exp_s.rd) || (u2 && bus.in_rs2_addr == exp_s.rd));
    exp_in_ready = bus.flush || (adv && !stl);
    nxt = exp_s;
    if (bus.flush) nxt.valid = 1'b0;
    else if (adv) begin
      if (bus.in_valid && !stl)
        nxt = model_decode(bus.in_opcode, bus.in_funct3, bus.in_funct7_b5, bus.in_rd_addr,
                           model_operand(bus.in_rs1_addr, bus.in_rs1_data),
                           model_operand(bus.in_rs2_addr, bus.in_rs2_data),
                           bus.in_imm, bus.in_pc);
      else nxt.valid = 1'b0;
    end
    @(posedge clk);
    #1;
    exp_s = nxt;
  endtask

  task automatic set_idle();
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.in_opcode = OPC_OP; bus.in_funct3 = 3'd0; bus.in_funct7_b5 = 1'b0;
    bus.in_pc = 32'h100; bus.in_imm = 32'd0;
    bus.in_rs1_addr = 5'd0; bus.in_rs2_addr = 5'd0; bus.in_rd_addr = 5'd0;
    bus.in_rs1_data = 32'd0; bus.in_rs2_data = 32'd0; bus.fwd_ex_data = 32'hdead_beef;
    bus.fwd_mem_valid = 1'b0; bus.fwd_wb_valid = 1'b0; bus.fwd_mem_rd = 5'd0;
    bus.fwd_wb_rd = 5'd0; bus.fwd_mem_data = 32'd0; bus.fwd_wb_data = 32'd0;
  endtask

  task automatic beat(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                      input logic [4:0] rd, rs1, rs2, input logic [31:0] d1, d2, imm);
    bus.in_valid = 1'b1; bus.in_opcode = opc; bus.in_funct3 = f3; bus.in_funct7_b5 = f7;
    bus.in_rd_addr = rd; bus.in_rs1_addr = rs1; bus.in_rs2_addr = rs2;
    bus.in_rs1_data = d1; bus.in_rs2_data = d2; bus.in_imm = imm; bus.in_pc = 32'h100;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_idle();
    #12;
    total++;
    if (act_s !== '0) begin
      bad++; $display("FAIL reset_outputs got %h want 0", act_s);
    end
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_s = '0;
  endtask

  task automatic test_alu_ops();
    beat(OPC_OP, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0);
    tick();
    total++;
    if ({act_s.valid, act_s.src_a, act_s.src_b, act_s.ctrl, act_s.rd, act_s.we} !==
        {1'b1, 32'd5, 32'd7, 4'b0010, 5'd3, 1'b1}) begin
      bad++; $display("FAIL add got %h want ADD x3 5/7", act_s);
    end
    beat(OPC_OP, 3'd0, 1'b1, 5'd4, 5'd1, 5'd2, 32'd9, 32'd3, 32'd0);
    tick();
    total++;
    if ({act_s.ctrl, act_s.src_a, act_s.src_b} !== {4'b0110, 32'd9, 32'd3}) begin
      bad++; $display("FAIL sub got %h want ctrl 0110 9/3", act_s);
    end
    beat(OPC_OPI, 3'd5, 1'b1, 5'd4, 5'd1, 5'd0, 32'h8000_0000, 32'd0, 32'd4);
    tick();
    total++;
    if ({act_s.ctrl, act_s.src_a, act_s.src_b} !== {4'b0011, 32'h8000_0000, 32'd4}) begin
      bad++; $display("FAIL srai got %h want ctrl 0011 b=4", act_s);
    end
    beat(OPC_BR, 3'd7, 1'b0, 5'd5, 5'd1, 5'd2, 32'd1, 32'd2, 32'd0);
    tick();
    total++;
    if ({act_s.ctrl, act_s.boz, act_s.we, act_s.is_branch, act_s.src_a, act_s.src_b} !==
        {4'b1111, 1'b1, 1'b0, 1'b1, 32'd1, 32'd2}) begin
      bad++; $display("FAIL bgeu got %h want ctrl 1111 boz=1 we=0", act_s);
    end
    beat(OPC_BR, 3'd0, 1'b0, 5'd5, 5'd1, 5'd2, 32'd1, 32'd2, 32'd0);
    tick();
    total++;
    if ({act_s.ctrl, act_s.boz} !== {4'b1110, 1'b0}) begin
      bad++; $display("FAIL beq got %h want ctrl 1110 boz=0", act_s);
    end
    beat(OPC_JAL, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0, 32'd0, 32'h40);
    bus.in_pc = 32'h200;
    tick();
    total++;
    if ({act_s.src_a, act_s.src_b, act_s.is_jump, act_s.we, act_s.ctrl} !==
        {32'h200, 32'd4, 1'b1, 1'b1, 4'b0010}) begin
      bad++; $display("FAIL jal got %h want a=pc b=4 jump", act_s);
    end
    beat(OPC_LUI, 3'd0, 1'b0, 5'd2, 5'd3, 5'd0, 32'hffff, 32'd0, 32'h1234_5000);
    tick();
    total++;
    if ({act_s.src_a, act_s.src_b, act_s.we} !== {32'd0, 32'h1234_5000, 1'b1}) begin
      bad++; $display("FAIL lui got %h want a=0 b=imm", act_s);
    end
  endtask

  task automatic test_forwarding();
    beat(OPC_OP, 3'd0, 1'b0, 5'd5, 5'd1, 5'd2, 32'd1, 32'd1, 32'd0);
    tick();
    bus.fwd_ex_data = 32'h10;
    bus.fwd_mem_valid = 1'b1; bus.fwd_mem_rd = 5'd5; bus.fwd_mem_data = 32'h20;
    bus.fwd_wb_valid = 1'b1; bus.fwd_wb_rd = 5'd5; bus.fwd_wb_data = 32'h30;
    beat(OPC_OP, 3'd0, 1'b0, 5'd6, 5'd5, 5'd5, 32'h99, 32'h99, 32'd0);
    tick();
    total++;
    if ({act_s.src_a, act_s.src_b} !== {32'h10, 32'h10}) begin
      bad++; $display("FAIL fwd_ex got %h/%h want 10/10", act_s.src_a, act_s.src_b);
    end
    tick();
    total++;
    if ({act_s.src_a, act_s.src_b} !== {32'h20, 32'h20}) begin
      bad++; $display("FAIL fwd_mem got %h/%h want 20/20", act_s.src_a, act_s.src_b);
    end
    bus.fwd_mem_valid = 1'b0;
    tick();
    total++;
    if ({act_s.src_a, act_s.src_b} !== {32'h30, 32'h30}) begin
      bad++; $display("FAIL fwd_wb got %h/%h want 30/30", act_s.src_a, act_s.src_b);
    end
    bus.fwd_wb_valid = 1'b0;
    tick();
    total++;
    if ({act_s.src_a, act_s.src_b} !== {32'h99, 32'h99}) begin
      bad++; $display("FAIL fwd_rf got %h/%h want 99/99", act_s.src_a, act_s.src_b);
    end
  endtask

  task automatic test_load_use();
    beat(OPC_LD, 3'd2, 1'b0, 5'd7, 5'd1, 5'd0, 32'h100, 32'd0, 32'd8);
    tick();
    total++;
    if ({act_s.is_load, act_s.we, act_s.ctrl, act_s.src_a, act_s.src_b} !==
        {1'b1, 1'b1, 4'b0010, 32'h100, 32'd8}) begin
      bad++; $display("FAIL lw got %h want load ADD 100/8", act_s);
    end
    beat(OPC_OP, 3'd0, 1'b0, 5'd8, 5'd7, 5'd0, 32'hbad, 32'h5, 32'd0);
    tick();
    total++;
    if ({act_in_ready, act_s.valid} !== 2'b00) begin
      bad++; $display("FAIL load_use_bubble got rdy=%b v=%b want 0 0", act_in_ready, act_s.valid);
    end
    bus.fwd_mem_valid = 1'b1; bus.fwd_mem_rd = 5'd7; bus.fwd_mem_data = 32'h77;
    tick();
    total++;
    if ({act_in_ready, act_s.valid, act_s.src_a, act_s.src_b, act_s.rd} !==
        {1'b1, 1'b1, 32'h77, 32'd0, 5'd8}) begin
      bad++; $display("FAIL load_use_fwd got rdy=%b %h want a=77 b=0", act_in_ready, act_s);
    end
    bus.fwd_mem_valid = 1'b0;
  endtask

  task automatic test_hold_flush();
    beat(OPC_OP, 3'd0, 1'b0, 5'd9, 5'd1, 5'd2, 32'h11, 32'h22, 32'd0);
    tick();
    bus.out_ready = 1'b0;
    beat(OPC_OP, 3'd0, 1'b0, 5'd10, 5'd3, 5'd4, 32'h33, 32'h44, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({act_in_ready, act_s.valid, act_s.src_a, act_s.src_b, act_s.rd} !==
          {1'b0, 1'b1, 32'h11, 32'h22, 5'd9}) begin
        bad++; $display("FAIL hold_%0d got rdy=%b %h want x9 held", i, act_in_ready, act_s);
      end
    end
    bus.flush = 1'b1;
    tick();
    total++;
    if ({act_in_ready, act_s.valid} !== 2'b10) begin
      bad++; $display("FAIL hold_flush got rdy=%b v=%b want 1 0", act_in_ready, act_s.valid);
    end
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick();
    total++;
    if (act_s.valid !== 1'b0) begin
      bad++; $display("FAIL flush_drop got v=%b want 0", act_s.valid);
    end
    beat(OPC_LD, 3'd2, 1'b0, 5'd7, 5'd1, 5'd0, 32'h0, 32'd0, 32'd0);
    tick();
    beat(OPC_OP, 3'd0, 1'b0, 5'd8, 5'd0, 5'd7, 32'd0, 32'd0, 32'd0);
    #1;
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL stall_ready got %b want 0", bus.in_ready);
    end
    bus.flush = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL stall_flush_ready got %b want 1", bus.in_ready);
    end
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    total++;
    if (act_s.valid !== 1'b0) begin
      bad++; $display("FAIL stall_flush got v=%b want 0", act_s.valid);
    end
    tick();
    total++;
    if (act_s.valid !== 1'b0) begin
      bad++; $display("FAIL stall_flush_drop got v=%b want 0", act_s.valid);
    end
  endtask

  task automatic test_illegal_x0();
    beat(7'h7f, 3'd0, 1'b0, 5'd5, 5'd1, 5'd2, 32'd1, 32'd2, 32'd0);
    tick();
    total++;
    if ({act_s.valid, act_s.illegal, act_s.we, act_s.is_load, act_s.is_store, act_s.is_branch,
         act_s.is_jump, act_s.ctrl} !== {1'b1, 1'b1, 5'b0, 4'b0010}) begin
      bad++; $display("FAIL illegal_opc got %h want illegal only", act_s);
    end
    beat(OPC_BR, 3'd2, 1'b0, 5'd5, 5'd1, 5'd2, 32'd1, 32'd2, 32'd0);
    tick();
    total++;
    if ({act_s.illegal, act_s.is_branch} !== 2'b10) begin
      bad++; $display("FAIL illegal_br got %h want illegal, no branch", act_s);
    end
    beat(OPC_OP, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd1, 32'd2, 32'd0);
    tick();
    total++;
    if ({act_s.valid, act_s.we} !== 2'b10) begin
      bad++; $display("FAIL x0_we got %h want valid, we=0", act_s);
    end
    bus.fwd_ex_data = 32'h77;
    bus.fwd_mem_valid = 1'b1; bus.fwd_mem_rd = 5'd0; bus.fwd_mem_data = 32'h55;
    bus.fwd_wb_valid = 1'b1; bus.fwd_wb_rd = 5'd0; bus.fwd_wb_data = 32'h66;
    beat(OPC_OP, 3'd0, 1'b0, 5'd11, 5'd0, 5'd0, 32'h88, 32'h88, 32'd0);
    tick();
    total++;
    if ({act_s.src_a, act_s.src_b} !== 64'd0) begin
      bad++; $display("FAIL x0_fwd got %h/%h want 0/0", act_s.src_a, act_s.src_b);
    end
    set_idle();
  endtask

  task automatic test_random();
    logic hold;
    hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        bus.in_valid     = ($urandom_range(0, 3) != 0);
        bus.in_opcode    = opc_tab[$urandom_range(0, 9)];
        bus.in_funct3    = 3'($urandom_range(0, 7));
        bus.in_funct7_b5 = 1'($urandom_range(0, 1));
        bus.in_rd_addr   = 5'($urandom_range(0, 3));
        bus.in_rs1_addr  = 5'($urandom_range(0, 3));
        bus.in_rs2_addr  = 5'($urandom_range(0, 3));
        bus.in_rs1_data  = $urandom;
        bus.in_rs2_data  = $urandom;
        bus.in_imm       = $urandom;
        bus.in_pc        = $urandom;
      end
      bus.out_ready     = ($urandom_range(0, 3) != 0);
      bus.flush         = ($urandom_range(0, 15) == 0);
      bus.fwd_ex_data   = $urandom;
      bus.fwd_mem_valid = 1'($urandom_range(0, 1));
      bus.fwd_mem_rd    = 5'($urandom_range(0, 3));
      bus.fwd_mem_data  = $urandom;
      bus.fwd_wb_valid  = 1'($urandom_range(0, 1));
      bus.fwd_wb_rd     = 5'($urandom_range(0, 3));
      bus.fwd_wb_data   = $urandom;
      tick();
      hold = bus.in_valid && !exp_in_ready;
      total++;
      if (act_in_ready !== exp_in_ready) begin
        bad++; $display("FAIL rand_ready[%0d] got %b want %b", i, act_in_ready, exp_in_ready);
      end
      total++;
      if (norm(act_s) !== norm(exp_s)) begin
        bad++; $display("FAIL rand_slot[%0d] got %h want %h", i, norm(act_s), norm(exp_s));
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_forwarding();
    test_load_use();
    test_hold_flush();
    test_illegal_x0();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
